// File: rtl/shift_register_seq.sv
// rtl/shift_register_seq.sv - parametrised universal shift register with multi-step sequencer
//
// Executes one command per start strobe: hold, shift right/left, parallel load,
// rotate right/left or arithmetic shift right, repeated amt times, followed by
// a one-cycle done pulse. busy is high from the accept edge until the done edge.
//
// Optional feature macro: SHREG_SOUT_EN (adds serial-out port s_out and strobe s_valid)
//
// Ports:
//   clk     in   clock, all state changes on rising edge
//   clr     in   synchronous active-low reset
//   start   in   command strobe, sampled only when idle
//   mode    in   [2:0] operation select, latched on accept
//   amt     in   [AMT_W-1:0] step count, latched on accept (load forces 1)
//   d       in   [WIDTH-1:0] parallel load data, latched on accept
//   l_in    in   serial bit entering LSB on shift left (live each step)
//   r_in    in   serial bit entering MSB on shift right (live each step)
//   q       out  [WIDTH-1:0] register contents
//   busy    out  command executing
//   done    out  one-cycle completion pulse
//   s_out   out  bit expelled by the last step (SHREG_SOUT_EN only)
//   s_valid out  high one cycle after each expelling step (SHREG_SOUT_EN only)

module shift_register_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             l_in,
    input  logic             r_in,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
`ifdef SHREG_SOUT_EN
    ,
    output logic             s_out,
    output logic             s_valid
`endif
);

    localparam logic [2:0] MODE_SRL  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROTR = 3'b100;
    localparam logic [2:0] MODE_ROTL = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [2:0]       mode_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dlat_q;
    logic [WIDTH-1:0] q_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] q_d;

    // Result of one step of the latched operation; hold/reserved keep q.
    always_comb begin
        q_d = q_q;
        case (mode_q)
            MODE_SRL:  q_d = {r_in, q_q[WIDTH-1:1]};
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], l_in};
            MODE_LOAD: q_d = dlat_q;
            MODE_ROTR: q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            default:   q_d = q_q;
        endcase
    end

`ifdef SHREG_SOUT_EN
    logic s_out_q;
    logic s_valid_q;
    logic sbit_d;
    logic sprod_d;

    // Right-moving operations expel the LSB, left-moving ones the MSB.
    always_comb begin
        sbit_d  = 1'b0;
        sprod_d = 1'b0;
        case (mode_q)
            MODE_SRL, MODE_ROTR, MODE_ASR: begin
                sbit_d  = q_q[0];
                sprod_d = 1'b1;
            end
            MODE_SHL, MODE_ROTL: begin
                sbit_d  = q_q[WIDTH-1];
                sprod_d = 1'b1;
            end
            default: begin
                sbit_d  = 1'b0;
                sprod_d = 1'b0;
            end
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            mode_q  <= 3'b000;
            cnt_q   <= '0;
            dlat_q  <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHREG_SOUT_EN
            s_out_q   <= 1'b0;
            s_valid_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef SHREG_SOUT_EN
            s_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        dlat_q  <= d;
                        // A load is always exactly one step regardless of amt.
                        cnt_q   <= (mode == MODE_LOAD) ? AMT_W'(1) : amt;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        q_q   <= q_d;
                        cnt_q <= cnt_q - AMT_W'(1);
`ifdef SHREG_SOUT_EN
                        if (sprod_d) begin
                            s_out_q   <= sbit_d;
                            s_valid_q <= 1'b1;
                        end
`endif
                    end else begin
                        // Terminal edge: no step, hand back to IDLE with done.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SHREG_SOUT_EN
    assign s_out   = s_out_q;
    assign s_valid = s_valid_q;
`endif

endmodule

// File: tb/tb_shift_register_seq.sv
// tb/tb_shift_register_seq.sv - self-checking bench for shift_register_seq

module tb_shift_register_seq;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  d;
    logic          l_in;
    logic          r_in;
    wire  [W-1:0]  q;
    wire           busy;
    wire           done;
`ifdef SHREG_SOUT_EN
    wire           s_out;
    wire           s_valid;
`endif

    shift_register_seq #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .d     (d),
        .l_in  (l_in),
        .r_in  (r_in),
        .q     (q),
        .busy  (busy),
        .done  (done)
`ifdef SHREG_SOUT_EN
        ,
        .s_out  (s_out),
        .s_valid(s_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        logic [2:0] amt;
        logic [7:0] d;
        logic       l_in;
        logic       r_in;
        logic [7:0] exp_q;
        int         exp_busy;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        int         busy_len;
    } exp_t;

    exp_t       sb[$];
    vec_t       vecs[16];
    logic [7:0] trace[$];
    int         busy_len;
    logic [7:0] sbits;
    int         sv_cnt;
    int         n_cmp  = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle (or in its done cycle); returns at
    // the negedge where done is observed, so the next command lands back-to-back.
    task automatic run_cmd(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        int   t;
        start = 1'b1;
        mode  = v.mode;
        amt   = v.amt;
        d     = v.d;
        l_in  = v.l_in;
        r_in  = v.r_in;
        e.q        = v.exp_q;
        e.busy_len = v.exp_busy;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        busy_len = 0;
        t        = 0;
        sbits    = 8'h00;
        sv_cnt   = 0;
        trace.delete();
        while (done !== 1'b1 && t < 40) begin
            if (busy === 1'b1) begin
                busy_len++;
                trace.push_back(q);
            end
`ifdef SHREG_SOUT_EN
            if (s_valid === 1'b1) begin
                sbits = {sbits[6:0], s_out};
                sv_cnt++;
            end
`endif
            @(negedge clk);
            t++;
        end
        check({name, "_done"}, {31'b0, done}, 32'd1);
        check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({name, "_q"}, {24'b0, q}, {24'b0, got.q});
            check({name, "_busy_len"}, busy_len, got.busy_len);
        end
    endtask

    initial begin
        int   t;
        int   dn;
        vec_t hv;

        //          mode    amt   d      l     r     exp_q  busy
        vecs[0]  = '{3'b011, 3'd3, 8'hA5, 1'b0, 1'b0, 8'hA5, 2};
        vecs[1]  = '{3'b001, 3'd3, 8'h00, 1'b0, 1'b1, 8'hF4, 4};
        vecs[2]  = '{3'b011, 3'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 2};
        vecs[3]  = '{3'b101, 3'd4, 8'h00, 1'b0, 1'b0, 8'h5A, 5};
        vecs[4]  = '{3'b011, 3'd5, 8'h84, 1'b0, 1'b0, 8'h84, 2};
        vecs[5]  = '{3'b110, 3'd2, 8'h00, 1'b0, 1'b0, 8'hE1, 3};
        vecs[6]  = '{3'b011, 3'd1, 8'hFF, 1'b0, 1'b0, 8'hFF, 2};
        vecs[7]  = '{3'b010, 3'd7, 8'h00, 1'b0, 1'b1, 8'h80, 8};
        vecs[8]  = '{3'b000, 3'd5, 8'h3C, 1'b1, 1'b1, 8'h80, 6};
        vecs[9]  = '{3'b111, 3'd3, 8'h3C, 1'b1, 1'b1, 8'h80, 4};
        vecs[10] = '{3'b001, 3'd0, 8'h00, 1'b1, 1'b1, 8'h80, 1};
        vecs[11] = '{3'b100, 3'd3, 8'h00, 1'b1, 1'b1, 8'h10, 4};
        vecs[12] = '{3'b010, 3'd2, 8'h00, 1'b1, 1'b0, 8'h43, 3};
        vecs[13] = '{3'b011, 3'd7, 8'hA5, 1'b0, 1'b0, 8'hA5, 2};
        vecs[14] = '{3'b100, 3'd3, 8'h00, 1'b0, 1'b0, 8'hB4, 4};
        vecs[15] = '{3'b001, 3'd7, 8'h00, 1'b1, 1'b0, 8'h01, 8};

        clr   = 1'b0;
        start = 1'b0;
        mode  = 3'b000;
        amt   = '0;
        d     = '0;
        l_in  = 1'b0;
        r_in  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_q", {24'b0, q}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
`ifdef SHREG_SOUT_EN
        check("reset_s_out", {31'b0, s_out}, 32'd0);
        check("reset_s_valid", {31'b0, s_valid}, 32'd0);
`endif
        clr = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_cmd(vecs[i], $sformatf("vec%0d", i));
            if (i == 1) begin
                check("srl_trace_len", trace.size(), 4);
                if (trace.size() == 4) begin
                    check("srl_step1", {24'b0, trace[1]}, 32'hD2);
                    check("srl_step2", {24'b0, trace[2]}, 32'hE9);
                    check("srl_step3", {24'b0, trace[3]}, 32'hF4);
                end
            end
            if (i == 5) begin
                check("asr_trace_len", trace.size(), 3);
                if (trace.size() == 3)
                    check("asr_step1", {24'b0, trace[1]}, 32'hC2);
            end
`ifdef SHREG_SOUT_EN
            if (i == 14) begin
                check("sout_valid_cnt", sv_cnt, 3);
                check("sout_bits", {24'b0, sbits}, 32'h05);
            end
`endif
        end

        // Reset in the middle of a command: aborted, no done.
        hv = '{3'b011, 3'd1, 8'hFF, 1'b0, 1'b0, 8'hFF, 2};
        run_cmd(hv, "pre_abort_load");
        start = 1'b1;
        mode  = 3'b001;
        amt   = 3'd5;
        r_in  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_after_accept", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("abort_first_step", {24'b0, q}, 32'h7F);
        clr = 1'b0;
        @(negedge clk);
        check("abort_q", {24'b0, q}, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        clr = 1'b1;
        dn  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("abort_no_done", dn, 0);
        hv = '{3'b011, 3'd0, 8'h3C, 1'b0, 1'b0, 8'h3C, 2};
        run_cmd(hv, "post_abort_load");

        // start held while busy with different mode/d must be ignored.
        start = 1'b1;
        mode  = 3'b010;
        amt   = 3'd4;
        l_in  = 1'b0;
        @(negedge clk);
        mode     = 3'b011;
        d        = 8'hFF;
        amt      = 3'd7;
        busy_len = 0;
        t        = 0;
        while (done !== 1'b1 && t < 40) begin
            if (busy === 1'b1) busy_len++;
            if (t == 2) start = 1'b0;
            @(negedge clk);
            t++;
        end
        check("ignore_done", {31'b0, done}, 32'd1);
        check("ignore_q", {24'b0, q}, 32'hC0);
        check("ignore_busy_len", busy_len, 5);
        @(negedge clk);
        check("ignore_no_restart", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
